// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
//   - IR field positions, opcode values, ALU function codes
//   - sequencer state encoding, opcode class, DataPath strobe bundle
//   - helper functions: opcode -> class, opcode -> ALU function
package mini_src_pkg;

    localparam int NREG_DEF  = 16;
    localparam int ALU_W_DEF = 5;

    // IR field positions (low bit of each field)
    localparam int OP_LSB = 27;   // [31:27]
    localparam int RA_LSB = 23;   // [26:23]
    localparam int RB_LSB = 19;   // [22:19]
    localparam int RC_LSB = 15;   // [18:15]

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_OR   = 5'b00101;
    localparam opcode_t OP_AND  = 5'b00110;
    localparam opcode_t OP_SHR  = 5'b00111;
    localparam opcode_t OP_SHL  = 5'b01000;
    localparam opcode_t OP_ROR  = 5'b01001;
    localparam opcode_t OP_ROL  = 5'b01010;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ANDI = 5'b01101;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE   = 5'b00000;
    localparam logic [4:0] ALU_ADD    = 5'b00011;
    localparam logic [4:0] ALU_SUB    = 5'b00100;
    localparam logic [4:0] ALU_SHR    = 5'b00101;
    localparam logic [4:0] ALU_SHL    = 5'b00110;
    localparam logic [4:0] ALU_ROR    = 5'b00111;
    localparam logic [4:0] ALU_ROL    = 5'b01000;
    localparam logic [4:0] ALU_AND    = 5'b01010;
    localparam logic [4:0] ALU_OR     = 5'b01011;
    localparam logic [4:0] ALU_MUL    = 5'b01110;
    localparam logic [4:0] ALU_DIV    = 5'b01111;
    localparam logic [4:0] ALU_PC_INC = 5'b11111;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU_R  = 3'd0,   // register-register ALU op
        CL_ALU_I  = 3'd1,   // ALU op with C operand
        CL_MULDIV = 3'd2,   // result split over HI/LO
        CL_NOP    = 3'd3,
        CL_HALT   = 3'd4,
        CL_ILL    = 3'd5
    } op_class_t;

    typedef struct packed {
        logic pout;
        logic pen;
        logic maren;
        logic mdren;
        logic mdrout;
        logic read;
        logic iren;
        logic yen;
        logic zhien;
        logic zloen;
        logic zhiout;
        logic zloout;
        logic hien;
        logic loen;
        logic cout;
    } strobes_t;

    function automatic op_class_t op_class(input opcode_t op);
        op_class_t cls;
        cls = CL_ILL;
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:       cls = CL_ALU_I;
            OP_MUL, OP_DIV:                 cls = CL_MULDIV;
            OP_NOP:                         cls = CL_NOP;
            OP_HALT:                        cls = CL_HALT;
            default:                        cls = CL_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic [4:0] alu_fn(input opcode_t op);
        logic [4:0] fn;
        fn = ALU_NONE;
        case (op)
            OP_ADD, OP_ADDI: fn = ALU_ADD;
            OP_SUB:          fn = ALU_SUB;
            OP_OR,  OP_ORI:  fn = ALU_OR;
            OP_AND, OP_ANDI: fn = ALU_AND;
            OP_SHR:          fn = ALU_SHR;
            OP_SHL:          fn = ALU_SHL;
            OP_ROR:          fn = ALU_ROR;
            OP_ROL:          fn = ALU_ROL;
            OP_MUL:          fn = ALU_MUL;
            OP_DIV:          fn = ALU_DIV;
            default:         fn = ALU_NONE;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/reg_decode_4to16.sv
// 4-bit register index plus enable -> one-hot 16-bit select.
//   idx    in  4   register number
//   en     in  1   when 0 the output is all zeros
//   onehot out 16  bit idx set when en=1
module reg_decode_4to16 (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == 4'(gi));
        end
    endgenerate
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC core: fetch -> decode -> execute,
// driving every DataPath strobe from registers.
//   clk, clr (async active-low reset)
//   ir       DataPath IR readback; run_req / stop_req / mem_rdy control inputs
//   R_en, R_out  one-hot register load / bus-drive enables
//   Pout..Cout   DataPath strobes; alu_control ALU function select
//   running  high outside IDLE/HALT; ill_op one-cycle pulse on undefined opcode
module control_sequencer
    import mini_src_pkg::*;
#(
    parameter int               NREG      = NREG_DEF,
    parameter int               ALU_W     = ALU_W_DEF,
    parameter logic [ALU_W-1:0] PC_INC_FN = ALU_W'(ALU_PC_INC)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             mem_rdy,
    output logic [NREG-1:0]  R_en,
    output logic [NREG-1:0]  R_out,
    output logic             Pout,
    output logic             Pen,
    output logic             MARen,
    output logic             MDRen,
    output logic             MDROut,
    output logic             Read,
    output logic             IRen,
    output logic             Yen,
    output logic             ZHIen,
    output logic             ZLOen,
    output logic             ZHIout,
    output logic             ZLOout,
    output logic             HIen,
    output logic             LOen,
    output logic             Cout,
    output logic [ALU_W-1:0] alu_control,
    output logic             running,
    output logic             ill_op
);
    state_t           state_q, state_d, end_state;
    logic             stop_q, stop_d;
    opcode_t          opcode_q, opcode_d;
    op_class_t        op_cls;
    strobes_t         ctl_q, ctl_d;
    logic [NREG-1:0]  r_en_q, r_en_d, r_out_q, r_out_d;
    logic [ALU_W-1:0] alu_q, alu_d;
    logic             running_q, running_d, ill_q, ill_d;

    logic [4:0]  ir_op;
    logic [3:0]  ir_ra, ir_rb, ir_rc;
    logic [3:0]  ren_idx, rout_idx;
    logic        ren_en, rout_en;
    logic [15:0] ren_hot, rout_hot;
    logic        unused_ir_low;

    assign ir_op = ir[OP_LSB +: 5];
    assign ir_ra = ir[RA_LSB +: 4];
    assign ir_rb = ir[RB_LSB +: 4];
    assign ir_rc = ir[RC_LSB +: 4];
    assign unused_ir_low = ^ir[14:0];  // C operand goes to DataPath directly

    // Next state. The opcode is captured from ir on the edge entering T3
    // and decoding from then on uses the latched copy.
    always_comb begin
        stop_d    = stop_q | stop_req;
        opcode_d  = (state_q == S_F2) ? ir_op : opcode_q;
        op_cls    = op_class(opcode_d);
        end_state = stop_d ? S_HALT : S_F0;
        state_d   = state_q;
        case (state_q)
            S_IDLE: if (run_req) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   if (mem_rdy) state_d = S_F2;
            S_F2:   state_d = S_T3;
            S_T3: begin
                case (op_cls)
                    CL_ALU_R, CL_ALU_I, CL_MULDIV: state_d = S_T4;
                    CL_HALT:                       state_d = S_HALT;
                    default:                       state_d = end_state;  // nop / illegal
                endcase
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (op_cls == CL_MULDIV) ? S_T6 : end_state;
            S_T6:   state_d = end_state;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so that the
    // registered copies are valid for the whole of that state.
    always_comb begin
        ctl_d     = '0;
        alu_d     = '0;
        ill_d     = 1'b0;
        ren_en    = 1'b0;
        ren_idx   = ir_ra;
        rout_en   = 1'b0;
        rout_idx  = ir_rb;
        running_d = (state_d != S_IDLE) && (state_d != S_HALT);
        case (state_d)
            S_F0: begin
                ctl_d.pout  = 1'b1;
                ctl_d.maren = 1'b1;
                ctl_d.zloen = 1'b1;
                alu_d       = PC_INC_FN;
            end
            S_F1: begin
                ctl_d.read  = 1'b1;
                ctl_d.mdren = 1'b1;
                // PC update happens once, not on every memory wait cycle
                if (state_q != S_F1) begin
                    ctl_d.zloout = 1'b1;
                    ctl_d.pen    = 1'b1;
                end
            end
            S_F2: begin
                ctl_d.mdrout = 1'b1;
                ctl_d.iren   = 1'b1;
            end
            S_T3: begin
                rout_en   = 1'b1;
                ctl_d.yen = 1'b1;
                ill_d     = (op_cls == CL_ILL);
            end
            S_T4: begin
                if (op_cls == CL_ALU_I) begin
                    ctl_d.cout = 1'b1;
                end else begin
                    rout_en  = 1'b1;
                    rout_idx = ir_rc;
                end
                alu_d       = ALU_W'(alu_fn(opcode_d));
                ctl_d.zloen = 1'b1;
                ctl_d.zhien = (op_cls == CL_MULDIV);
            end
            S_T5: begin
                ctl_d.zloout = 1'b1;
                if (op_cls == CL_MULDIV) ctl_d.loen = 1'b1;
                else                     ren_en     = 1'b1;
            end
            S_T6: begin
                ctl_d.zhiout = 1'b1;
                ctl_d.hien   = 1'b1;
            end
            default: ;
        endcase
    end

    reg_decode_4to16 u_dec_en  (.idx(ren_idx),  .en(ren_en),  .onehot(ren_hot));
    reg_decode_4to16 u_dec_out (.idx(rout_idx), .en(rout_en), .onehot(rout_hot));

    assign r_en_d  = NREG'(ren_hot);
    assign r_out_d = NREG'(rout_hot);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            stop_q    <= 1'b0;
            opcode_q  <= '0;
            ctl_q     <= '0;
            r_en_q    <= '0;
            r_out_q   <= '0;
            alu_q     <= '0;
            running_q <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stop_q    <= stop_d;
            opcode_q  <= opcode_d;
            ctl_q     <= ctl_d;
            r_en_q    <= r_en_d;
            r_out_q   <= r_out_d;
            alu_q     <= alu_d;
            running_q <= running_d;
            ill_q     <= ill_d;
        end
    end

    assign R_en        = r_en_q;
    assign R_out       = r_out_q;
    assign Pout        = ctl_q.pout;
    assign Pen         = ctl_q.pen;
    assign MARen       = ctl_q.maren;
    assign MDRen       = ctl_q.mdren;
    assign MDROut      = ctl_q.mdrout;
    assign Read        = ctl_q.read;
    assign IRen        = ctl_q.iren;
    assign Yen         = ctl_q.yen;
    assign ZHIen       = ctl_q.zhien;
    assign ZLOen       = ctl_q.zloen;
    assign ZHIout      = ctl_q.zhiout;
    assign ZLOout      = ctl_q.zloout;
    assign HIen        = ctl_q.hien;
    assign LOen        = ctl_q.loen;
    assign Cout        = ctl_q.cout;
    assign alu_control = alu_q;
    assign running     = running_q;
    assign ill_op      = ill_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, OR, memory wait, mul,
// immediate, undefined opcode, stop, reset mid-instruction, run+stop.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr, run_req, stop_req, mem_rdy;
    logic [31:0] ir;
    logic [15:0] R_en, R_out;
    logic        Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen;
    logic        ZHIen, ZLOen, ZHIout, ZLOout, HIen, LOen, Cout;
    logic [4:0]  alu_control;
    logic        running, ill_op;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] B_POUT   = 15'h4000;
    localparam logic [14:0] B_PEN    = 15'h2000;
    localparam logic [14:0] B_MAREN  = 15'h1000;
    localparam logic [14:0] B_MDREN  = 15'h0800;
    localparam logic [14:0] B_MDROUT = 15'h0400;
    localparam logic [14:0] B_READ   = 15'h0200;
    localparam logic [14:0] B_IREN   = 15'h0100;
    localparam logic [14:0] B_YEN    = 15'h0080;
    localparam logic [14:0] B_ZHIEN  = 15'h0040;
    localparam logic [14:0] B_ZLOEN  = 15'h0020;
    localparam logic [14:0] B_ZHIOUT = 15'h0010;
    localparam logic [14:0] B_ZLOOUT = 15'h0008;
    localparam logic [14:0] B_HIEN   = 15'h0004;
    localparam logic [14:0] B_LOEN   = 15'h0002;
    localparam logic [14:0] B_COUT   = 15'h0001;

    wire [14:0] strb = {Pout, Pen, MARen, MDRen, MDROut, Read, IRen, Yen,
                        ZHIen, ZLOen, ZHIout, ZLOout, HIen, LOen, Cout};
    wire [53:0] allv = {R_en, R_out, strb, alu_control, running, ill_op};

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .run_req(run_req), .stop_req(stop_req),
        .mem_rdy(mem_rdy), .R_en(R_en), .R_out(R_out), .Pout(Pout), .Pen(Pen),
        .MARen(MARen), .MDRen(MDRen), .MDROut(MDROut), .Read(Read), .IRen(IRen),
        .Yen(Yen), .ZHIen(ZHIen), .ZLOen(ZLOen), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .HIen(HIen), .LOen(LOen), .Cout(Cout), .alu_control(alu_control),
        .running(running), .ill_op(ill_op)
    );

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; bus exclusivity checked every cycle.
    task automatic step();
        int n;
        @(posedge clk);
        #1;
        n = $countones(R_out) + int'(Pout) + int'(MDROut) + int'(ZHIout)
            + int'(ZLOout) + int'(Cout);
        chk("bus_excl", 64'(n <= 1), 64'd1);
    endtask

    task automatic chk_state(input string tag, input logic [14:0] s, input logic [15:0] ren,
                             input logic [15:0] rout, input logic [4:0] alu,
                             input logic run, input logic ill);
        chk({tag, ".strb"},  64'(strb),        64'(s));
        chk({tag, ".R_en"},  64'(R_en),        64'(ren));
        chk({tag, ".R_out"}, 64'(R_out),       64'(rout));
        chk({tag, ".alu"},   64'(alu_control), 64'(alu));
        chk({tag, ".run"},   64'(running),     64'(run));
        chk({tag, ".ill"},   64'(ill_op),      64'(ill));
    endtask

    task automatic chk_f0(input string tag);
        chk_state(tag, B_POUT | B_MAREN | B_ZLOEN, 16'h0, 16'h0, 5'b11111, 1'b1, 1'b0);
    endtask

    // From F0 with mem_rdy=1: check F1 then F2.
    task automatic fetch_rest(input string tag);
        step();
        chk_state({tag, ".F1"}, B_ZLOOUT | B_PEN | B_READ | B_MDREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        step();
        chk_state({tag, ".F2"}, B_MDROUT | B_IREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
    endtask

    initial begin
        clr = 1'b0; run_req = 1'b0; stop_req = 1'b0; mem_rdy = 1'b1; ir = 32'h0;

        // Reset held while inputs toggle
        for (int i = 0; i < 3; i++) begin
            run_req = i[0]; stop_req = ~i[0]; mem_rdy = i[1];
            step();
            chk("reset_hold", 64'(allv), 64'd0);
        end
        clr = 1'b1; run_req = 1'b0; stop_req = 1'b0; mem_rdy = 1'b1;
        step();
        chk("idle", 64'(allv), 64'd0);
        $display("txn reset: idle after release");

        // OR R1,R2,R3
        ir = 32'h28918000; run_req = 1'b1;
        step();
        chk_f0("or.F0");
        run_req = 1'b0;
        fetch_rest("or");
        step(); chk_state("or.T3", B_YEN, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0);
        step(); chk_state("or.T4", B_ZLOEN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0);
        step(); chk_state("or.T5", B_ZLOOUT, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0);
        step(); chk_f0("or.next_F0");
        $display("txn OR r1,r2,r3: 6 cycles");

        // Same OR with three memory wait cycles in F1
        mem_rdy = 1'b0;
        step(); chk_state("wait.F1a", B_ZLOOUT | B_PEN | B_READ | B_MDREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(); chk_state("wait.F1w", B_READ | B_MDREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        end
        mem_rdy = 1'b1;
        step(); chk_state("wait.F2", B_MDROUT | B_IREN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        step(); chk_state("wait.T3", B_YEN, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0);
        step(); chk_state("wait.T4", B_ZLOEN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0);
        step(); chk_state("wait.T5", B_ZLOOUT, 16'h0002, 16'h0, 5'd0, 1'b1, 1'b0);
        step(); chk_f0("wait.next_F0");
        $display("txn OR with memory wait: Read held 4 cycles");

        // MUL R4,R5,R6
        ir = mk_ir(5'b01111, 4'd4, 4'd5, 4'd6);
        fetch_rest("mul");
        step(); chk_state("mul.T3", B_YEN, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0);
        step(); chk_state("mul.T4", B_ZHIEN | B_ZLOEN, 16'h0, 16'h0040, 5'b01110, 1'b1, 1'b0);
        step(); chk_state("mul.T5", B_ZLOOUT | B_LOEN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        step(); chk_state("mul.T6", B_ZHIOUT | B_HIEN, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
        step(); chk_f0("mul.next_F0");
        $display("txn MUL r5,r6: 7 cycles");

        // ADDI R7,R8,C
        ir = mk_ir(5'b01100, 4'd7, 4'd8, 4'd0) | 32'h00000123;
        fetch_rest("addi");
        step(); chk_state("addi.T3", B_YEN, 16'h0, 16'h0100, 5'd0, 1'b1, 1'b0);
        step(); chk_state("addi.T4", B_COUT | B_ZLOEN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        step(); chk_state("addi.T5", B_ZLOOUT, 16'h0080, 16'h0, 5'd0, 1'b1, 1'b0);
        step(); chk_f0("addi.next_F0");
        $display("txn ADDI r7,r8,C");

        // Undefined opcode
        ir = mk_ir(5'b11111, 4'd0, 4'd1, 4'd0);
        fetch_rest("ill");
        step(); chk_state("ill.T3", B_YEN, 16'h0, 16'h0002, 5'd0, 1'b1, 1'b1);
        step(); chk_f0("ill.next_F0");
        $display("txn undefined opcode: ill_op pulse");

        // OR R9,R10,R11 with stop_req pulsed in T4
        ir = mk_ir(5'b00101, 4'd9, 4'd10, 4'd11);
        fetch_rest("stop");
        step(); chk_state("stop.T3", B_YEN, 16'h0, 16'h0400, 5'd0, 1'b1, 1'b0);
        step(); chk_state("stop.T4", B_ZLOEN, 16'h0, 16'h0800, 5'b01011, 1'b1, 1'b0);
        stop_req = 1'b1;
        step(); chk_state("stop.T5", B_ZLOOUT, 16'h0200, 16'h0, 5'd0, 1'b1, 1'b0);
        stop_req = 1'b0;
        step(); chk("stop.halt", 64'(allv), 64'd0);
        run_req = 1'b1;
        step(); chk("stop.halt_stays", 64'(allv), 64'd0);
        run_req = 1'b0;
        $display("txn OR r9 with stop: halted");

        // Reset asserted during T4
        clr = 1'b0;
        step();
        clr = 1'b1;
        ir = 32'h28918000; run_req = 1'b1;
        step(); chk_f0("rst.F0");
        run_req = 1'b0;
        fetch_rest("rst");
        step(); chk_state("rst.T3", B_YEN, 16'h0, 16'h0004, 5'd0, 1'b1, 1'b0);
        step(); chk_state("rst.T4", B_ZLOEN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1 chk("rst.async_zero", 64'(allv), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step(); chk("rst.no_ren", 64'(allv), 64'd0);
        end
        clr = 1'b1;
        $display("txn reset in T4: abandoned");

        // run_req and stop_req together in IDLE, NOP instruction then HALT
        ir = mk_ir(5'b11010, 4'd0, 4'd3, 4'd0);
        run_req = 1'b1; stop_req = 1'b1;
        step(); chk_f0("rs.F0");
        run_req = 1'b0; stop_req = 1'b0;
        fetch_rest("rs");
        step(); chk_state("rs.T3", B_YEN, 16'h0, 16'h0008, 5'd0, 1'b1, 1'b0);
        step(); chk("rs.halt", 64'(allv), 64'd0);
        $display("txn NOP with run+stop: halted after first instruction");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
